gx4000_cart_reader: RTL and testbench

CPU-side read path for the Plus/GX4000 cartridge image that the cartridge loader writes into SDRAM.
- Decodes Plus ROM mapping: RMR, RMR2 and upper-ROM select.
- Translates Z80 reads in enabled ROM windows to SDRAM byte addresses and runs a request/acknowledge handshake.
- Holds the CPU via wait until data returns.
- Sits between the CPU bus and the SDRAM arbiter, beside the cartridge loader.

---
 rtl/gx4000_pkg.sv | 40 ++++
 rtl/gx4000_rom_map.sv | 93 +++++++++
 rtl/gx4000_cart_reader.sv | 170 +++++++++++++++++
 tb/tb_gx4000_cart_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gx4000_pkg.sv
// Shared types and constants for the Plus/GX4000 cartridge read path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gx4000_pkg;

   // Read-path FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } rd_state_t;

   // Gate-array command codes in cpu_data[7:6] / cpu_data[7:5].
   // RMR2 (101) is a subset of the RMR prefix (10), so RMR2 is decoded first.
   localparam logic [1:0] RMR_CODE  = 2'b10;
   localparam logic [2:0] RMR2_CODE = 3'b101;

   // Upper-ROM select values 0x80-0x9F address cartridge pages.
   localparam logic [2:0] UPPER_SEL_CART = 3'b100;

   // Window base addresses.
   localparam logic [15:0] LOWER_BASE_0 = 16'h0000;
   localparam logic [15:0] LOWER_BASE_1 = 16'h4000;
   localparam logic [15:0] LOWER_BASE_2 = 16'h8000;
   localparam logic [15:0] UPPER_BASE   = 16'hC000;

   // Default SDRAM byte address of cartridge page 0; the loader uses the same.
   localparam logic [24:0] CART_BASE_DEF = 25'h0400000;

   // Lower ROM window base selected by rmr2[4:3]; 11 folds back onto 0x0000.
   function automatic logic [15:0] lower_base(input logic [1:0] sel);
      case (sel)
         2'b01:   lower_base = LOWER_BASE_1;
         2'b10:   lower_base = LOWER_BASE_2;
         default: lower_base = LOWER_BASE_0;
      endcase
   endfunction

endpackage

// File: rtl/gx4000_rom_map.sv
// Plus ROM mapping registers (RMR, RMR2, upper select) and window/page/address decode.
// Latency: register writes take effect next cycle; decode is combinational.
// Backpressure: none; writes are always accepted when plus_mode is set.
module gx4000_rom_map
   import gx4000_pkg::*;
#(
   parameter logic [24:0] CART_BASE      = CART_BASE_DEF,
   parameter int          DEF_UPPER_PAGE = 3
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        plus_mode,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   input  logic        cpu_wr,
   output logic        win_match,
   output logic [18:0] rd_tag,
   output logic [24:0] rd_addr,
   output logic        map_wr
);

   localparam logic [4:0] DEF_PAGE = 5'(DEF_UPPER_PAGE);

   logic       lower_en_q, lower_en_d;
   logic       upper_en_q, upper_en_d;
   logic [4:0] rmr2_q, rmr2_d;
   logic [7:0] upper_sel_q, upper_sel_d;

   logic        ga_wr;
   logic        sel_wr;
   logic [15:0] low_base;
   logic        lower_hit;
   logic        upper_hit;
   logic [4:0]  page;

   // Decode I/O writes into next values of the mapping registers.
   always_comb begin
      lower_en_d  = lower_en_q;
      upper_en_d  = upper_en_q;
      rmr2_d      = rmr2_q;
      upper_sel_d = upper_sel_q;
      map_wr      = 1'b0;
      ga_wr       = cpu_wr & plus_mode & (cpu_addr[15:14] == 2'b01);
      sel_wr      = cpu_wr & plus_mode & ~cpu_addr[13];
      if (ga_wr) begin
         if (cpu_data[7:5] == RMR2_CODE) begin
            rmr2_d = cpu_data[4:0];
            map_wr = 1'b1;
         end else if (cpu_data[7:6] == RMR_CODE) begin
            lower_en_d = ~cpu_data[2];
            upper_en_d = ~cpu_data[3];
            map_wr     = 1'b1;
         end
      end
      if (sel_wr) begin
         upper_sel_d = cpu_data;
         map_wr      = 1'b1;
      end
   end

   // Mapping register state.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         lower_en_q  <= 1'b1;
         upper_en_q  <= 1'b1;
         rmr2_q      <= 5'd0;
         upper_sel_q <= 8'h00;
      end else begin
         lower_en_q  <= lower_en_d;
         upper_en_q  <= upper_en_d;
         rmr2_q      <= rmr2_d;
         upper_sel_q <= upper_sel_d;
      end
   end

   // Window match, page selection (lower wins on overlap) and SDRAM address.
   always_comb begin
      low_base  = lower_base(rmr2_q[4:3]);
      lower_hit = lower_en_q & (cpu_addr[15:14] == low_base[15:14]);
      upper_hit = upper_en_q & (cpu_addr[15:14] == UPPER_BASE[15:14]);
      if (lower_hit) begin
         page = {2'b00, rmr2_q[2:0]};
      end else if (upper_sel_q[7:5] == UPPER_SEL_CART) begin
         page = upper_sel_q[4:0];
      end else begin
         page = DEF_PAGE;
      end
      win_match = lower_hit | upper_hit;
      rd_tag    = {page, cpu_addr[13:0]};
      rd_addr   = CART_BASE + {6'b000000, rd_tag};
   end

endmodule

// File: rtl/gx4000_cart_reader.sv
// CPU read path into the cartridge image in SDRAM with a one-entry read cache.
// Latency: cache hit / bypass 0 cycles; miss = 1 request cycle + SDRAM ack delay.
// Backpressure: cpu_wait holds the CPU until mem_ack or the timeout ends the read.
module gx4000_cart_reader
   import gx4000_pkg::*;
#(
   parameter logic [24:0] CART_BASE      = CART_BASE_DEF,
   parameter int          TIMEOUT        = 255,
   parameter int          DEF_UPPER_PAGE = 3
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        plus_mode,
   input  logic        cart_valid,
   input  logic        ioctl_download,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   output logic [7:0]  cpu_dout,
   output logic        cpu_wait,
   output logic        rom_hit,
   output logic [24:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_ack,
   input  logic [7:0]  mem_din,
   output logic        timeout_err
);

   localparam int          TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

   rd_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [24:0]   mem_addr_q, mem_addr_d;
   logic [18:0]   tag_q, tag_d;
   logic [15:0]   req_addr_q, req_addr_d;
   logic [7:0]    dout_q, dout_d;
   logic          err_q, err_d;
   logic          cache_vld_q, cache_vld_d;
   logic [18:0]   cache_tag_q, cache_tag_d;
   logic [7:0]    cache_dat_q, cache_dat_d;

   logic        win_match;
   logic [18:0] rd_tag;
   logic [24:0] rd_addr;
   logic        map_wr;
   logic        cache_hit;
   logic        bypass_ff;

   gx4000_rom_map #(
      .CART_BASE      (CART_BASE),
      .DEF_UPPER_PAGE (DEF_UPPER_PAGE)
   ) u_rom_map (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .plus_mode (plus_mode),
      .cpu_addr  (cpu_addr),
      .cpu_data  (cpu_data),
      .cpu_wr    (cpu_wr),
      .win_match (win_match),
      .rd_tag    (rd_tag),
      .rd_addr   (rd_addr),
      .map_wr    (map_wr)
   );

   assign mem_addr    = mem_addr_q;
   assign timeout_err = err_q;

   // Read FSM next state, cache update and CPU-facing outputs.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      mem_addr_d  = mem_addr_q;
      tag_d       = tag_q;
      req_addr_d  = req_addr_q;
      dout_d      = dout_q;
      err_d       = err_q;
      cache_vld_d = cache_vld_q;
      cache_tag_d = cache_tag_q;
      cache_dat_d = cache_dat_q;
      mem_rd      = 1'b0;
      cpu_wait    = 1'b0;
      cpu_dout    = dout_q;
      rom_hit     = plus_mode & cpu_rd & win_match;
      cache_hit   = cache_vld_q & (cache_tag_q == rd_tag);
      // No image, or loader busy rewriting it: answer 0xFF without SDRAM.
      bypass_ff   = ~cart_valid | ioctl_download;

      case (state_q)
         ST_IDLE: begin
            if (rom_hit) begin
               if (bypass_ff) begin
                  cpu_dout = 8'hFF;
               end else if (cache_hit) begin
                  cpu_dout = cache_dat_q;
               end else begin
                  cpu_wait   = 1'b1;
                  state_d    = ST_REQ;
                  mem_addr_d = rd_addr;
                  tag_d      = rd_tag;
                  req_addr_d = cpu_addr;
               end
            end
         end
         ST_REQ: begin
            cpu_wait = 1'b1;
            mem_rd   = 1'b1;
            timer_d  = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            cpu_wait = 1'b1;
            if (mem_ack) begin
               dout_d      = mem_din;
               cache_vld_d = 1'b1;
               cache_tag_d = tag_q;
               cache_dat_d = mem_din;
               state_d     = ST_DONE;
            end else if (timer_q == TMR_LAST) begin
               dout_d  = 8'hFF;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DONE: begin
            // The CPU ends the cycle by dropping cpu_rd or moving to a new address.
            if (!cpu_rd || (cpu_addr != req_addr_q)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Remapping or reloading makes the cached byte stale; this beats a same-cycle fill.
      if (map_wr || ioctl_download) begin
         cache_vld_d = 1'b0;
      end
   end

   // Read path state registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         mem_addr_q  <= '0;
         tag_q       <= '0;
         req_addr_q  <= '0;
         dout_q      <= 8'hFF;
         err_q       <= 1'b0;
         cache_vld_q <= 1'b0;
         cache_tag_q <= '0;
         cache_dat_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         mem_addr_q  <= mem_addr_d;
         tag_q       <= tag_d;
         req_addr_q  <= req_addr_d;
         dout_q      <= dout_d;
         err_q       <= err_d;
         cache_vld_q <= cache_vld_d;
         cache_tag_q <= cache_tag_d;
         cache_dat_q <= cache_dat_d;
      end
   end

endmodule

// File: tb/tb_gx4000_cart_reader.sv
// Directed bench for gx4000_cart_reader: mapping decode, SDRAM handshake, cache, timeout, reset.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: mem_ack is issued by the bench a programmable number of cycles after mem_rd.
module tb_gx4000_cart_reader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        plus_mode;
   logic        cart_valid;
   logic        ioctl_download;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [7:0]  cpu_dout;
   logic        cpu_wait;
   logic        rom_hit;
   logic [24:0] mem_addr;
   logic        mem_rd;
   logic        mem_ack;
   logic [7:0]  mem_din;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk_sys = ~clk_sys;

   gx4000_cart_reader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .plus_mode      (plus_mode),
      .cart_valid     (cart_valid),
      .ioctl_download (ioctl_download),
      .cpu_addr       (cpu_addr),
      .cpu_data       (cpu_data),
      .cpu_wr         (cpu_wr),
      .cpu_rd         (cpu_rd),
      .cpu_dout       (cpu_dout),
      .cpu_wait       (cpu_wait),
      .rom_hit        (rom_hit),
      .mem_addr       (mem_addr),
      .mem_rd         (mem_rd),
      .mem_ack        (mem_ack),
      .mem_din        (mem_din),
      .timeout_err    (timeout_err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a;
      cpu_data = d;
      cpu_wr   = 1'b1;
      tick();
      cpu_wr   = 1'b0;
      tick();
   endtask

   // One CPU read. ack_dly < 0 withholds mem_ack. wait_req counts cpu_wait cycles
   // from the mem_rd cycle through the ack cycle.
   task automatic do_read(input logic [15:0] a, input int ack_dly, input logic [7:0] din,
                          output int n_rd, output int wait_req, output logic first_wait,
                          output logic first_hit, output logic [7:0] dout,
                          output logic [24:0] addr_seen);
      int   rd_cyc;
      logic done;
      rd_cyc     = -1;
      done       = 1'b0;
      n_rd       = 0;
      wait_req   = 0;
      first_wait = 1'b0;
      first_hit  = 1'b0;
      dout       = 8'h00;
      addr_seen  = '0;
      cpu_addr   = a;
      cpu_rd     = 1'b1;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk_sys);
         if (k == 0) begin
            first_wait = cpu_wait;
            first_hit  = rom_hit;
         end
         if (mem_rd) begin
            n_rd++;
            addr_seen = mem_addr;
            rd_cyc    = k;
         end
         if (!cpu_wait) begin
            dout = cpu_dout;
            done = 1'b1;
            break;
         end
         if (rd_cyc >= 0) wait_req++;
         tick();
         mem_ack = 1'b0;
         if (rd_cyc >= 0 && ack_dly >= 0 && (k + 1) == rd_cyc + ack_dly) begin
            mem_ack = 1'b1;
            mem_din = din;
         end
      end
      check_val("read_completes", 32'(done), 32'd1);
      tick();
      mem_ack = 1'b0;
      cpu_rd  = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int          n_rd;
      int          wait_req;
      logic        fw;
      logic        fh;
      logic [7:0]  dout;
      logic [24:0] adr;

      reset          = 1'b1;
      plus_mode      = 1'b1;
      cart_valid     = 1'b1;
      ioctl_download = 1'b0;
      cpu_addr       = 16'h0000;
      cpu_data       = 8'h00;
      cpu_wr         = 1'b0;
      cpu_rd         = 1'b0;
      mem_ack        = 1'b0;
      mem_din        = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk_sys);
      check_val("rst_dout", 32'(cpu_dout), 32'hFF);
      check_val("rst_wait", 32'(cpu_wait), 32'd0);
      check_val("rst_mem_rd", 32'(mem_rd), 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
      check_val("rst_rom_hit", 32'(rom_hit), 32'd0);
      tick();

      // 1: default map, lower page 0 at 0x0000, ack 3 cycles after mem_rd
      do_read(16'h0000, 3, 8'hA5, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t1_rom_hit", 32'(fh), 32'd1);
      check_val("t1_wait_same_cycle", 32'(fw), 32'd1);
      check_val("t1_mem_rd_pulses", 32'(n_rd), 32'd1);
      check_val("t1_mem_addr", 32'(adr), 32'h0400000);
      check_val("t1_wait_cycles", 32'(wait_req), 32'd4);
      check_val("t1_dout", 32'(dout), 32'hA5);

      // 2: RMR2 0xAD -> lower window at 0x4000, page 5
      reg_write(16'h7F00, 8'hAD);
      do_read(16'h4010, 2, 8'h5C, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t2_mem_addr", 32'(adr), 32'h0414010);
      check_val("t2_dout", 32'(dout), 32'h5C);
      do_read(16'h0000, 2, 8'h00, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t2_no_hit_0000", 32'(fh), 32'd0);
      check_val("t2_no_hit_wait", 32'(fw), 32'd0);
      check_val("t2_no_hit_mem_rd", 32'(n_rd), 32'd0);

      // 3: upper ROM select, cartridge page vs default page
      reg_write(16'hDF00, 8'h87);
      do_read(16'hC123, 1, 8'h31, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t3_sel87_addr", 32'(adr), 32'h041C123);
      check_val("t3_sel87_dout", 32'(dout), 32'h31);
      reg_write(16'hDF00, 8'h07);
      do_read(16'hC123, 1, 8'h32, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t3_sel07_addr", 32'(adr), 32'h040C123);
      check_val("t3_sel07_dout", 32'(dout), 32'h32);

      // 4: cache hit on repeat, invalidated by a mapping write
      do_read(16'h4020, 2, 8'h11, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t4_first_mem_rd", 32'(n_rd), 32'd1);
      do_read(16'h4020, 2, 8'hEE, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t4_hit_mem_rd", 32'(n_rd), 32'd0);
      check_val("t4_hit_wait", 32'(fw), 32'd0);
      check_val("t4_hit_dout", 32'(dout), 32'h11);
      reg_write(16'h7F00, 8'hAD);
      do_read(16'h4020, 2, 8'h22, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t4_inval_mem_rd", 32'(n_rd), 32'd1);
      check_val("t4_inval_dout", 32'(dout), 32'h22);

      // 5: withheld ack -> 255 WAIT cycles after the request cycle, then 0xFF
      do_read(16'hC200, -1, 8'h00, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t5_mem_rd", 32'(n_rd), 32'd1);
      check_val("t5_wait_cycles", 32'(wait_req), 32'd256);
      check_val("t5_dout", 32'(dout), 32'hFF);
      check_val("t5_timeout_err", 32'(timeout_err), 32'd1);
      do_read(16'h4020, 2, 8'hEE, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t5_cache_kept_mem_rd", 32'(n_rd), 32'd0);
      check_val("t5_cache_kept_dout", 32'(dout), 32'h22);

      // 6: load cache with 0xC300, reset mid-WAIT on 0xC200, late ack ignored
      do_read(16'hC300, 1, 8'h66, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t6_fill_dout", 32'(dout), 32'h66);
      cpu_addr = 16'hC200;
      cpu_rd   = 1'b1;
      tick();
      tick();
      tick();
      @(negedge clk_sys);
      check_val("t6_in_wait", 32'(cpu_wait), 32'd1);
      tick();
      reset  = 1'b1;
      cpu_rd = 1'b0;
      tick();
      reset   = 1'b0;
      mem_ack = 1'b1;
      mem_din = 8'h5A;
      @(negedge clk_sys);
      check_val("t6_rst_mem_rd", 32'(mem_rd), 32'd0);
      check_val("t6_rst_wait", 32'(cpu_wait), 32'd0);
      check_val("t6_rst_dout", 32'(cpu_dout), 32'hFF);
      check_val("t6_rst_err", 32'(timeout_err), 32'd0);
      check_val("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
      tick();
      mem_ack = 1'b0;
      @(negedge clk_sys);
      check_val("t6_late_ack_dout", 32'(cpu_dout), 32'hFF);
      tick();
      do_read(16'hC300, 2, 8'h77, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t6_cache_inval_mem_rd", 32'(n_rd), 32'd1);
      check_val("t6_cache_inval_addr", 32'(adr), 32'h040C300);
      check_val("t6_cache_inval_dout", 32'(dout), 32'h77);

      cart_valid = 1'b0;
      do_read(16'hC300, 2, 8'h00, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t6_nocart_dout", 32'(dout), 32'hFF);
      check_val("t6_nocart_wait", 32'(fw), 32'd0);
      check_val("t6_nocart_mem_rd", 32'(n_rd), 32'd0);
      cart_valid = 1'b1;

      ioctl_download = 1'b1;
      do_read(16'hC300, 2, 8'h00, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t6_dl_dout", 32'(dout), 32'hFF);
      check_val("t6_dl_mem_rd", 32'(n_rd), 32'd0);
      ioctl_download = 1'b0;

      plus_mode = 1'b0;
      do_read(16'hC300, 2, 8'h00, n_rd, wait_req, fw, fh, dout, adr);
      check_val("t6_noplus_hit", 32'(fh), 32'd0);
      check_val("t6_noplus_wait", 32'(fw), 32'd0);
      check_val("t6_noplus_mem_rd", 32'(n_rd), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
